player_bullet_gen: RTL
======================

# player_bullet_gen

Pixel-generation stage for the player ship and its bullet, directly downstream of the VGA sync/timing generator. Consumes the generator's pixel tick, `video_on` flag and `x`/`y` scan position. Produces registered 12-bit RGB for the board DAC. Ship position and bullet flight update once per frame during vertical blanking, driven by synchronised, debounced button levels.

## Interface
- `SHIP_X0`, 304: ship left edge after reset.
- `SHIP_Y`, 440: ship top row, fixed.
- `SHIP_W` / `SHIP_H`, 32 / 16: ship box size in pixels.
- `SHIP_SPEED`, 2: ship pixels moved per frame.
- `BULLET_W` / `BULLET_H`, 2 / 8: bullet box size.
- `BULLET_SPEED`, 4: bullet pixels moved upward per frame.
- `clk_100MHz` in 1: system clock, the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `p_tick` in 1: 25 MHz pixel-enable pulse, one clock wide, every 4th clock.
- `video_on` in 1: current `x`/`y` lies in the 640x480 active area.
- `x` in 10: horizontal scan count, 0-799.
- `y` in 10: vertical scan count, 0-524.
- `btn_left`, `btn_right`, `btn_fire` in 1 each: level inputs, already synchronised and debounced.
- `bullet_clear` in 1: one-clock pulse from collision logic that kills the bullet.
- `rgb` out 12: {R[3:0],G[3:0],B[3:0]}, registered.
- `frame_tick` out 1: one-clock pulse at the start of each frame update.
- `ship_x` out 10: current ship left edge.
- `bullet_active` out 1: high while the bullet is in flight.
- `bullet_x`, `bullet_y` out 10 each: current bullet top-left corner.

## Operation
- **frame_tick:** registered pulse. It is 1 in the clock after a clock where `p_tick && x==0 && y==480`, otherwise 0. Exactly one pulse per frame; all game-state updates occur on it.
- **Ship, on frame_tick:**
  - `btn_left && !btn_right`: `ship_x -= SHIP_SPEED`, saturating at 0.
  - `btn_right && !btn_left`: `ship_x += SHIP_SPEED`, saturating at `640-SHIP_W` (608).
  - Both pressed or neither pressed: hold.
  - Compare before subtracting; arithmetic never underflows 10 bits.
- **Bullet FSM, states IDLE and FLY:**
  - **IDLE → FLY:** on frame_tick when `btn_fire` is high and `fire_prev` is low, i.e. a fire edge sampled per frame. Load `bullet_x = ship_x + SHIP_W/2 - BULLET_W/2` and `bullet_y = SHIP_Y - BULLET_H` (432).
  - **FLY:** on frame_tick, if `bullet_y < BULLET_SPEED` go to IDLE, else `bullet_y -= BULLET_SPEED`.
  - Fire presses while in FLY are ignored.
  - `fire_prev <= btn_fire` on every frame_tick, regardless of state.
  - `bullet_clear` forces IDLE on the next clock from any state and beats a coincident frame_tick. `bullet_x`/`bullet_y` hold their values.
  - `bullet_active` = (state == FLY).
- **Pixel select, evaluated on p_tick:**
  - `!video_on`: `12'h000`.
  - Inside ship box (`ship_x ≤ x < ship_x+SHIP_W`, `SHIP_Y ≤ y < SHIP_Y+SHIP_H`): `12'h0F0`.
  - Inside bullet box while FLY: `12'hFFF`.
  - Otherwise background `12'h000`.
  - The ship has priority over the bullet.
- **Reset values:** `rgb=0`, `frame_tick=0`, `ship_x=SHIP_X0`, state IDLE, `bullet_active=0`, `bullet_x=0`, `bullet_y=0`, `fire_prev=0`.

## Timing
- `rgb` updates one clock after the `p_tick` clock that presents `x`/`y`. It then holds until the next `p_tick`, 4 clocks later.
- `frame_tick` occurs in vertical blanking (line 480). Positions never change inside the active area, so there is no tearing.
- Button-to-motion latency: the change appears at the first frame_tick after the press, and is visible from the next frame's line 0.
- `bullet_clear` latency: `bullet_active` falls 1 clock after the pulse. The bullet disappears from the current frame from that point on.
- `reset_n` low mid-frame: all outputs return to reset values immediately. Counting resumes from the upstream `x`/`y`.

## Configuration
- `PLAYER_WRAP_EN` defined: edge moves wrap instead of saturating.
  - Left from `ship_x < SHIP_SPEED` loads 608.
  - Right from `ship_x + SHIP_SPEED > 608` loads 0.
- `PLAYER_WRAP_EN` undefined: saturating behaviour as specified in Operation.

## Test plan
- Reset, then 1 frame, no buttons → `ship_x=304`, `bullet_active=0`; `rgb=12'h0F0` at (304,440); `rgb=12'h000` at (303,440) and at (700,100).
- Hold `btn_left` for 160 frames → `ship_x` steps 2 per frame to 0 and stays at 0. With `PLAYER_WRAP_EN` defined, the frame after reaching 0 gives `ship_x=608`.
- `btn_fire` high for 3 frames with `ship_x=304` → exactly one launch: `bullet_x=319`, `bullet_y=432`. Then 428, 424, …; return to IDLE after `bullet_y` reaches 0. A second press is accepted only after the bullet returns to IDLE.
- `bullet_clear` asserted in the same clock as a `frame_tick` while FLY at `bullet_y=200` → `bullet_active=0` next clock; `bullet_y` holds 200; no `12'hFFF` pixels drawn afterwards.
- `btn_left` and `btn_right` both high for 10 frames → `ship_x` unchanged. `reset_n` pulsed low at (320,240) → `rgb=0` and `ship_x=304` while reset is low.
- Count `frame_tick` over 3 frames → exactly 3 pulses, each one clock wide, each following `x=0`, `y=480`.

Source files
------------

// File: rtl/player_bullet_gen.sv
// player_bullet_gen: ship and bullet pixel stage behind the VGA timing block.
// Define PLAYER_WRAP_EN to wrap the ship at the screen edges instead of saturating.
module player_bullet_gen #(
  parameter int SHIP_X0      = 304,
  parameter int SHIP_Y       = 440,
  parameter int SHIP_W       = 32,
  parameter int SHIP_H       = 16,
  parameter int SHIP_SPEED   = 2,
  parameter int BULLET_W     = 2,
  parameter int BULLET_H     = 8,
  parameter int BULLET_SPEED = 4
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  input  logic        bullet_clear,
  output logic [11:0] rgb,
  output logic        frame_tick,
  output logic [9:0]  ship_x,
  output logic        bullet_active,
  output logic [9:0]  bullet_x,
  output logic [9:0]  bullet_y
);

  localparam logic [9:0]  X_MAX  = 10'(640 - SHIP_W);
  localparam logic [9:0]  S_SPD  = 10'(SHIP_SPEED);
  localparam logic [9:0]  SY0    = 10'(SHIP_Y);
  localparam logic [9:0]  SY1    = 10'(SHIP_Y + SHIP_H);
  localparam logic [10:0] SW     = 11'(SHIP_W);
  localparam logic [9:0]  BX_OFF = 10'(SHIP_W / 2 - BULLET_W / 2);
  localparam logic [9:0]  BY0    = 10'(SHIP_Y - BULLET_H);
  localparam logic [9:0]  B_SPD  = 10'(BULLET_SPEED);
  localparam logic [9:0]  BH     = 10'(BULLET_H);
  localparam logic [10:0] BW     = 11'(BULLET_W);

`ifdef PLAYER_WRAP_EN
  localparam logic [9:0] LEFT_OVF  = X_MAX;
  localparam logic [9:0] RIGHT_OVF = 10'd0;
`else
  localparam logic [9:0] LEFT_OVF  = 10'd0;
  localparam logic [9:0] RIGHT_OVF = X_MAX;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    FLY  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        fire_prev;
  logic        fire_edge;
  logic        frame_hit;
  logic        mv_l;
  logic        mv_r;
  logic [9:0]  ship_nx;
  logic [9:0]  bx_nx;
  logic [9:0]  by_nx;
  logic [10:0] xe;
  logic        in_ship;
  logic        in_bullet;
  logic [11:0] rgb_nx;

  assign frame_hit = p_tick && (x == 10'd0) && (y == 10'd480);
  assign fire_edge = btn_fire && !fire_prev;
  assign mv_l      = btn_left && !btn_right;
  assign mv_r      = btn_right && !btn_left;
  assign bullet_active = (state == FLY);

  // Compare before stepping so the 10-bit position never under/overflows.
  always_comb begin
    ship_nx = ship_x;
    unique case (1'b1)
      mv_l: begin
        if (ship_x < S_SPD) ship_nx = LEFT_OVF;
        else                ship_nx = ship_x - S_SPD;
      end
      mv_r: begin
        if ({1'b0, ship_x} + {1'b0, S_SPD} > {1'b0, X_MAX})
          ship_nx = RIGHT_OVF;
        else
          ship_nx = ship_x + S_SPD;
      end
      default: ship_nx = ship_x;
    endcase
  end

  // A clear from collision logic wins over any frame update.
  always_comb begin
    state_nx = state;
    bx_nx    = bullet_x;
    by_nx    = bullet_y;
    if (bullet_clear) begin
      state_nx = IDLE;
    end else if (frame_tick) begin
      unique case (state)
        IDLE: begin
          if (fire_edge) begin
            state_nx = FLY;
            bx_nx    = ship_x + BX_OFF;
            by_nx    = BY0;
          end
        end
        FLY: begin
          if (bullet_y < B_SPD) state_nx = IDLE;
          else                  by_nx    = bullet_y - B_SPD;
        end
      endcase
    end
  end

  assign xe = {1'b0, x};

  always_comb begin
    in_ship = (xe >= {1'b0, ship_x})
           && (xe < {1'b0, ship_x} + SW)
           && (y >= SY0)
           && (y < SY1);
    in_bullet = (state == FLY)
             && (xe >= {1'b0, bullet_x})
             && (xe < {1'b0, bullet_x} + BW)
             && (y >= bullet_y)
             && (y < bullet_y + BH);
  end

  // Ship sits on top of the bullet where they overlap.
  always_comb begin
    rgb_nx = 12'h000;
    priority case (1'b1)
      !video_on: rgb_nx = 12'h000;
      in_ship:   rgb_nx = 12'h0F0;
      in_bullet: rgb_nx = 12'hFFF;
      default:   rgb_nx = 12'h000;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      rgb        <= 12'h000;
      frame_tick <= 1'b0;
      ship_x     <= 10'(SHIP_X0);
      state      <= IDLE;
      bullet_x   <= 10'd0;
      bullet_y   <= 10'd0;
      fire_prev  <= 1'b0;
    end else begin
      frame_tick <= frame_hit;
      state      <= state_nx;
      bullet_x   <= bx_nx;
      bullet_y   <= by_nx;
      if (frame_tick) begin
        ship_x    <= ship_nx;
        fire_prev <= btn_fire;
      end
      if (p_tick) rgb <= rgb_nx;
    end
  end

endmodule
